// File: rtl/frost32_mem_access_unit.sv
// Frost32 CPU-side memory access unit: takes one load/store from the pipeline,
// drives the main-memory bus, waits MEM_LATENCY cycles and returns extended load data.
module frost32_mem_access_unit #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        req_mem_access,
   output logic [31:0] addr,
   output logic        data_inout_access_type,
   output logic [1:0]  data_inout_access_size,
   output logic [31:0] data_out,
   input  logic [31:0] data_in
);

   // Handshake: a request transfers on the rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE, so anything offered while busy is ignored.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_ERR
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(MEM_LATENCY - 1);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       hold_signed;
   logic       misaligned;
   logic       bad_req;

   assign req_ready  = (state == ST_IDLE);
   assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
   assign bad_req    = misaligned || (req_size == 2'd3);

   function automatic logic [31:0] mask_wdata(input logic [31:0] w, input logic [1:0] sz);
      case (sz)
         2'd0:    return {24'h0, w[7:0]};
         2'd1:    return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] extend_rdata(input logic [31:0] d, input logic [1:0] sz,
                                                input logic sgn);
      case (sz)
         2'd0:    return {{24{sgn & d[7]}}, d[7:0]};
         2'd1:    return {{16{sgn & d[15]}}, d[15:0]};
         default: return d;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                  <= ST_IDLE;
         wait_cnt               <= 4'd0;
         hold_signed            <= 1'b0;
         resp_valid             <= 1'b0;
         resp_err               <= 1'b0;
         resp_rdata             <= 32'h0;
         req_mem_access         <= 1'b0;
         addr                   <= 32'h0;
         data_inout_access_type <= 1'b0;
         data_inout_access_size <= 2'd0;
         data_out               <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (bad_req) begin
                     // Bad requests answer immediately and leave the bus fields untouched.
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                     state      <= ST_ERR;
                  end else begin
                     req_mem_access         <= 1'b1;
                     addr                   <= req_addr;
                     data_inout_access_type <= req_write;
                     data_inout_access_size <= req_size;
                     data_out               <= req_write ? mask_wdata(req_wdata, req_size) : 32'h0;
                     hold_signed            <= req_signed;
                     state                  <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               req_mem_access <= 1'b0;
               wait_cnt       <= WAIT_INIT;
               state          <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  resp_rdata <= data_inout_access_type ? 32'h0 :
                                extend_rdata(data_in, data_inout_access_size, hold_signed);
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  state      <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               resp_valid <= 1'b0;
               state      <= ST_IDLE;
            end
            ST_ERR: begin
               resp_valid <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Directed bench for frost32_mem_access_unit: one instance at MEM_LATENCY=1, one at 4.
module tb_frost32_mem_access_unit;

   localparam int LAT1 = 1;
   localparam int LAT4 = 4;
   localparam logic [31:0] GARBAGE = 32'hA5A5A5A5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance with MEM_LATENCY=1
   logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, data_in = 32'h0;
   logic        req_ready, resp_valid, resp_err, req_mem_access, data_inout_access_type;
   logic [1:0]  data_inout_access_size;
   logic [31:0] resp_rdata, addr, data_out;

   // Instance with MEM_LATENCY=4
   logic        req_valid_4 = 1'b0, req_write_4 = 1'b0, req_signed_4 = 1'b0;
   logic [1:0]  req_size_4 = 2'd0;
   logic [31:0] req_addr_4 = 32'h0, req_wdata_4 = 32'h0, data_in_4 = 32'h0;
   logic        req_ready_4, resp_valid_4, resp_err_4, req_mem_access_4, data_inout_access_type_4;
   logic [1:0]  data_inout_access_size_4;
   logic [31:0] resp_rdata_4, addr_4, data_out_4;

   frost32_mem_access_unit #(.MEM_LATENCY(LAT1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_err(resp_err), .resp_rdata(resp_rdata), .req_mem_access(req_mem_access),
      .addr(addr), .data_inout_access_type(data_inout_access_type),
      .data_inout_access_size(data_inout_access_size), .data_out(data_out), .data_in(data_in)
   );

   frost32_mem_access_unit #(.MEM_LATENCY(LAT4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_4), .req_ready(req_ready_4),
      .req_write(req_write_4), .req_size(req_size_4), .req_signed(req_signed_4),
      .req_addr(req_addr_4), .req_wdata(req_wdata_4), .resp_valid(resp_valid_4),
      .resp_err(resp_err_4), .resp_rdata(resp_rdata_4), .req_mem_access(req_mem_access_4),
      .addr(addr_4), .data_inout_access_type(data_inout_access_type_4),
      .data_inout_access_size(data_inout_access_size_4), .data_out(data_out_4),
      .data_in(data_in_4)
   );

   int n_checks = 0;
   int n_pass = 0;

   // Observations from the last issue() on the L=1 instance
   int          obs_strobe_cyc, obs_resp_cyc, obs_strobes, obs_resps;
   logic        obs_ready0, obs_ready1, obs_type, obs_err;
   logic [1:0]  obs_size;
   logic [31:0] obs_addr, obs_dout, obs_rdata;

   // Presents one request in cycle 0 and returns bus read data only in cycle 1+LAT1.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus_rd);
      obs_strobe_cyc = -1; obs_resp_cyc = -1; obs_strobes = 0; obs_resps = 0;
      obs_ready0 = 1'b0; obs_ready1 = 1'b1; obs_type = 1'b0; obs_err = 1'b0;
      obs_size = 2'd0; obs_addr = 32'h0; obs_dout = 32'h0; obs_rdata = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
      req_addr = a; req_wdata = wd; data_in = GARBAGE;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) obs_ready0 = req_ready;
         if (c == 1) obs_ready1 = req_ready;
         if (req_mem_access) begin
            obs_strobes++;
            if (obs_strobe_cyc < 0) begin
               obs_strobe_cyc = c; obs_addr = addr; obs_type = data_inout_access_type;
               obs_size = data_inout_access_size; obs_dout = data_out;
            end
         end
         if (resp_valid) begin
            obs_resps++;
            if (obs_resp_cyc < 0) begin
               obs_resp_cyc = c; obs_err = resp_err; obs_rdata = resp_rdata;
            end
         end
         @(posedge clk); #1;
         if (c == 0) req_valid = 1'b0;
         data_in = (c + 1 == 1 + LAT1) ? bus_rd : GARBAGE;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({resp_valid, resp_err, resp_rdata, req_mem_access, addr, data_inout_access_type,
           data_inout_access_size, data_out} !== '0)
         $display("FAIL reset_outputs: got nonzero registered outputs, required all 0");
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready);
      else n_pass++;
   endtask

   task automatic test_load32();
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678);
      n_checks++;
      if (obs_ready0 !== 1'b1 || obs_ready1 !== 1'b0)
         $display("FAIL load32_ready: got c0=%b c1=%b required 1 0", obs_ready0, obs_ready1);
      else n_pass++;
      n_checks++;
      if (obs_strobe_cyc !== 1 || obs_strobes !== 1)
         $display("FAIL load32_strobe: got cycle %0d count %0d required 1 1", obs_strobe_cyc, obs_strobes);
      else n_pass++;
      n_checks++;
      if (obs_addr !== 32'h100 || obs_type !== 1'b0 || obs_size !== 2'd2)
         $display("FAIL load32_bus: got addr %h type %b size %0d required 00000100 0 2",
                  obs_addr, obs_type, obs_size);
      else n_pass++;
      n_checks++;
      if (obs_resp_cyc !== 3 || obs_resps !== 1 || obs_err !== 1'b0)
         $display("FAIL load32_resp: got cycle %0d pulses %0d err %b required 3 1 0",
                  obs_resp_cyc, obs_resps, obs_err);
      else n_pass++;
      n_checks++;
      if (obs_rdata !== 32'h1234_5678)
         $display("FAIL load32_rdata: got %h required 12345678", obs_rdata);
      else n_pass++;
   endtask

   task automatic test_load_subword();
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 32'h1234_569A);
      n_checks++;
      if (obs_rdata !== 32'hFFFF_FF9A || obs_size !== 2'd0 || obs_addr !== 32'h101)
         $display("FAIL load8_signed: got rdata %h size %0d addr %h required ffffff9a 0 00000101",
                  obs_rdata, obs_size, obs_addr);
      else n_pass++;
      issue(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_569A);
      n_checks++;
      if (obs_rdata !== 32'h0000_009A)
         $display("FAIL load8_unsigned: got %h required 0000009a", obs_rdata);
      else n_pass++;
      issue(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 32'h5555_8001);
      n_checks++;
      if (obs_rdata !== 32'hFFFF_8001)
         $display("FAIL load16_signed: got %h required ffff8001", obs_rdata);
      else n_pass++;
      issue(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 32'h5555_8001);
      n_checks++;
      if (obs_rdata !== 32'h0000_8001)
         $display("FAIL load16_unsigned: got %h required 00008001", obs_rdata);
      else n_pass++;
   endtask

   task automatic test_store();
      issue(1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0);
      n_checks++;
      if (obs_dout !== 32'h0000_BEEF || obs_type !== 1'b1 || obs_size !== 2'd1 ||
          obs_addr !== 32'h200 || obs_strobe_cyc !== 1)
         $display("FAIL store16_bus: got dout %h type %b size %0d addr %h cyc %0d required 0000beef 1 1 00000200 1",
                  obs_dout, obs_type, obs_size, obs_addr, obs_strobe_cyc);
      else n_pass++;
      n_checks++;
      if (obs_resp_cyc !== 3 || obs_rdata !== 32'h0 || obs_err !== 1'b0)
         $display("FAIL store16_resp: got cycle %0d rdata %h err %b required 3 00000000 0",
                  obs_resp_cyc, obs_rdata, obs_err);
      else n_pass++;
      issue(1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h1122_3344, 32'h0);
      n_checks++;
      if (obs_dout !== 32'h0000_0044 || obs_size !== 2'd0)
         $display("FAIL store8_bus: got dout %h size %0d required 00000044 0", obs_dout, obs_size);
      else n_pass++;
   endtask

   task automatic test_errors();
      // Leave nonzero read data behind so the zeroing on error is visible.
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D);
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 32'h1111_1111);
      n_checks++;
      if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_strobes !== 0)
         $display("FAIL err_misaligned32: got cycle %0d err %b rdata %h strobes %0d required 1 1 00000000 0",
                  obs_resp_cyc, obs_err, obs_rdata, obs_strobes);
      else n_pass++;
      issue(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111);
      n_checks++;
      if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_resps !== 1 || obs_strobes !== 0)
         $display("FAIL err_size3: got cycle %0d err %b pulses %0d strobes %0d required 1 1 1 0",
                  obs_resp_cyc, obs_err, obs_resps, obs_strobes);
      else n_pass++;
      issue(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'hFFFF_FFFF, 32'h0);
      n_checks++;
      if (obs_resp_cyc !== 1 || obs_err !== 1'b1 || obs_strobes !== 0)
         $display("FAIL err_misaligned16: got cycle %0d err %b strobes %0d required 1 1 0",
                  obs_resp_cyc, obs_err, obs_strobes);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acc0, acc1, busy_ready, resp_cyc;
      logic [31:0] rd;
      acc0 = -1; acc1 = -1; busy_ready = 0; resp_cyc = -1; rd = 32'h0;
      @(posedge clk); #1;
      req_valid_4 = 1'b1; req_write_4 = 1'b0; req_size_4 = 2'd2; req_signed_4 = 1'b0;
      req_addr_4 = 32'h0000_0300; data_in_4 = 32'hCAFE_F00D;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (req_ready_4) begin
            if (acc0 < 0) acc0 = c;
            else if (acc1 < 0) acc1 = c;
         end
         if (c >= 1 && c <= 6 && req_ready_4) busy_ready++;
         if (resp_valid_4 && resp_cyc < 0) begin
            resp_cyc = c; rd = resp_rdata_4;
         end
         @(posedge clk); #1;
      end
      req_valid_4 = 1'b0;
      repeat (8) @(posedge clk);
      n_checks++;
      if (acc0 !== 0 || acc1 !== 7)
         $display("FAIL b2b_accept: got %0d %0d required 0 7", acc0, acc1);
      else n_pass++;
      n_checks++;
      if (busy_ready !== 0)
         $display("FAIL b2b_ready_busy: got %0d ready cycles required 0", busy_ready);
      else n_pass++;
      n_checks++;
      if (resp_cyc !== 6 || rd !== 32'hCAFE_F00D)
         $display("FAIL b2b_resp: got cycle %0d rdata %h required 6 cafef00d", resp_cyc, rd);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      int late_resps;
      late_resps = 0;
      @(posedge clk); #1;
      req_valid_4 = 1'b1; req_addr_4 = 32'h0000_0304; req_size_4 = 2'd2; req_write_4 = 1'b0;
      @(posedge clk); #1;
      req_valid_4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready_4 !== 1'b0) $display("FAIL midwait_busy: got ready %b required 0", req_ready_4);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({resp_valid_4, resp_err_4, resp_rdata_4, req_mem_access_4, addr_4,
           data_inout_access_type_4, data_inout_access_size_4, data_out_4} !== '0)
         $display("FAIL midwait_reset_outputs: got addr %h rdata %h required 0 0", addr_4, resp_rdata_4);
      else n_pass++;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_ready_4 !== 1'b1) $display("FAIL midwait_ready: got %b required 1", req_ready_4);
      else n_pass++;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (resp_valid_4 || req_mem_access_4) late_resps++;
      end
      n_checks++;
      if (late_resps !== 0)
         $display("FAIL midwait_no_resp: got %0d active cycles required 0", late_resps);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_load32();
      test_load_subword();
      test_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
